// File: rtl/sfr_pkg.sv
// Shared definitions for the serial frame receiver: control bus encoding and FSM states.
package sfr_pkg;

  localparam logic [1:0] CTRL_RIGHT  = 2'b00;
  localparam logic [1:0] CTRL_LEFT   = 2'b01;
  localparam logic [1:0] CTRL_RETAIN = 2'b10;
  localparam logic [1:0] CTRL_CLEAR  = 2'b11;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/sfr_out_buffer.sv
// One-deep valid/ready holding register for completed words; flags overrun when a
// completed word arrives while the held word is neither consumed nor replaceable.
module sfr_out_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             data_ready,
  input  logic             clear_overrun,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             overrun
);

  logic consume;
  logic can_load;

  assign consume  = data_valid && data_ready;
  assign can_load = !data_valid || data_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load && can_load) begin
        data_out   <= load_data;
        data_valid <= 1'b1;
      end else if (consume) begin
        data_valid <= 1'b0;
      end
      // a load and a clear never share a cycle: clearing uses the non-shift control code
      if (load && !can_load) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// Reassembles WIDTH-bit words from a serial stream using the shift register's control code.
// Optional even-parity trailer bit enabled by SERIAL_FRAME_RECEIVER_PARITY_EN.
//
// state   | meaning
// IDLE    | no frame in progress; next shift bit starts a frame
// COLLECT | frame in progress in the latched direction
module serial_frame_receiver
  import sfr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_input,
  input  logic [1:0]       control,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic [CNT_W-1:0] bit_count,
  output logic             frame_error,
  output logic             overrun,
  output logic             parity_err
);

`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ferr_q, ferr_d;

  logic             shift_en;
  logic             dir_req;
  logic             restart;
  logic             is_last;
  logic             complete;
  logic             clear_sticky;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic             parity_bad;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      shreg_q <= '0;
      count_q <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    shreg_d      = shreg_q;
    count_d      = count_q;
    ferr_d       = 1'b0;
    complete     = 1'b0;
    clear_sticky = 1'b0;

    dir_req  = control[0];
    shift_en = (control == CTRL_RIGHT) || (control == CTRL_LEFT);
    // a new frame starts from an empty register, whether from IDLE or after a direction change
    restart  = (state_q == IDLE) || (dir_req != dir_q);
    base     = restart ? '0 : shreg_q;
    shifted  = dir_req ? {base[WIDTH-2:0], serial_input} : {serial_input, base[WIDTH-1:1]};
    is_last  = !restart && (count_q == CNT_W'(FRAME_LEN - 1));

    if (control == CTRL_CLEAR) begin
      state_d      = IDLE;
      shreg_d      = '0;
      count_d      = '0;
      clear_sticky = 1'b1;
    end else if (shift_en) begin
      ferr_d = (state_q == COLLECT) && (dir_req != dir_q);
      dir_d  = dir_req;
      if (is_last) begin
        complete = 1'b1;
        state_d  = IDLE;
        shreg_d  = '0;
        count_d  = '0;
      end else begin
        state_d = COLLECT;
        shreg_d = shifted;
        count_d = restart ? CNT_W'(1) : count_q + 1'b1;
      end
    end
  end

`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
  logic parity_q;

  // the final bit is the parity trailer, so the word is already complete in shreg_q
  assign word       = shreg_q;
  assign parity_bad = (^shreg_q) ^ serial_input;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (clear_sticky) begin
      parity_q <= 1'b0;
    end else if (complete && parity_bad) begin
      parity_q <= 1'b1;
    end
  end

  assign parity_err = parity_q;
`else
  assign word       = shifted;
  assign parity_bad = 1'b0;
  assign parity_err = 1'b0;
`endif

  sfr_out_buffer #(.WIDTH(WIDTH)) u_out_buffer (
    .clock         (clock),
    .reset         (reset),
    .load          (complete),
    .load_data     (word),
    .data_ready    (data_ready),
    .clear_overrun (clear_sticky),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .overrun       (overrun)
  );

  assign bit_count   = count_q;
  assign frame_error = ferr_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench for serial_frame_receiver: a bit-queue reference model predicts words and
// flags; a negedge monitor pops expected words whenever the DUT hands one over.
module tb_serial_frame_receiver;
  import sfr_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 2);
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             serial_input;
  logic [1:0]       control;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic [CNT_W-1:0] bit_count;
  logic             frame_error;
  logic             overrun;
  logic             parity_err;

  serial_frame_receiver #(.WIDTH(WIDTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .serial_input (serial_input),
    .control      (control),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .bit_count    (bit_count),
    .frame_error  (frame_error),
    .overrun      (overrun),
    .parity_err   (parity_err)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int errors  = 0;

  // reference model state
  bit               bits[$];
  bit               m_dir;
  bit               m_valid;
  bit               m_over;
  bit               m_perr;
  bit               m_ferr;
  logic [WIDTH-1:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] assemble(input bit d);
    logic [WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (d) w[WIDTH-1-i] = bits[i];
      else   w[i] = bits[i];
    end
    return w;
  endfunction

  // Apply one cycle of inputs, advance the model, clock, then check flags.
  task automatic step(input logic [1:0] c, input logic b, input logic r);
    logic [WIDTH-1:0] w;
    bit               complete;
    control      = c;
    serial_input = b;
    data_ready   = r;
    complete     = 1'b0;
    m_ferr       = 1'b0;
    w            = '0;
    if (c == CTRL_CLEAR) begin
      bits.delete();
      m_over = 1'b0;
      m_perr = 1'b0;
    end else if (c != CTRL_RETAIN) begin
      if (bits.size() != 0 && c[0] != m_dir) begin
        m_ferr = 1'b1;
        bits.delete();
      end
      if (bits.size() == 0) m_dir = c[0];
      bits.push_back(b);
      if (bits.size() == FRAME_LEN) begin
        complete = 1'b1;
        w = assemble(m_dir);
        if (FRAME_LEN > WIDTH && ((^w) != bits[FRAME_LEN-1])) m_perr = 1'b1;
        bits.delete();
      end
    end
    if (complete) begin
      if (m_valid && !r) m_over = 1'b1;
      else begin
        sb.push_back(w);
        m_valid = 1'b1;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    @(posedge clock);
    #1;
    chk("bit_count", bit_count, bits.size());
    chk("frame_error", frame_error, m_ferr);
    chk("data_valid", data_valid, m_valid);
    chk("overrun", overrun, m_over);
    chk("parity_err", parity_err, m_perr);
  endtask

  function automatic logic frame_bit(input bit d, input logic [WIDTH-1:0] w, input int i,
                                     input bit flip);
    if (i >= WIDTH) return (^w) ^ flip;
    return d ? w[WIDTH-1-i] : w[i];
  endfunction

  task automatic send_frame(input bit d, input logic [WIDTH-1:0] w, input logic r_body,
                            input logic r_last, input bit flip);
    for (int i = 0; i < FRAME_LEN; i++)
      step({1'b0, d}, frame_bit(d, w, i, flip), (i == FRAME_LEN - 1) ? r_last : r_body);
  endtask

  task automatic consume();
    step(CTRL_RETAIN, 1'b0, 1'b1);
  endtask

  initial begin : monitor
    logic [WIDTH-1:0] exp;
    forever begin
      @(negedge clock);
      if (!reset && data_valid === 1'b1 && data_ready === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL word_pop: got %0h expected no word", data_out);
        end else begin
          exp = sb.pop_front();
          if (data_out !== exp) begin
            errors++;
            $display("FAIL word: got %0h expected %0h at %0t", data_out, exp, $time);
          end
        end
      end
    end
  end

  initial begin : stim
    logic cur;
    int   r;
    logic [1:0] c;
    reset        = 1'b1;
    control      = CTRL_RETAIN;
    serial_input = 1'b0;
    data_ready   = 1'b0;
    m_dir = 0; m_valid = 0; m_over = 0; m_perr = 0; m_ferr = 0;
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_valid", data_valid, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_bit_count", bit_count, 0);
    chk("rst_overrun", overrun, 0);

    // right-shift 0xAC
    send_frame(1'b0, 8'hAC, 1'b0, 1'b0, 1'b0);
    chk("right_word", data_out, 8'hAC);
    consume();

    // left-shift 0xC9 with a retain after the 4th bit
    for (int i = 0; i < 4; i++) step(CTRL_LEFT, frame_bit(1'b1, 8'hC9, i, 1'b0), 1'b0);
    step(CTRL_RETAIN, 1'b1, 1'b0);
    chk("retain_count", bit_count, 4);
    for (int i = 4; i < FRAME_LEN; i++) step(CTRL_LEFT, frame_bit(1'b1, 8'hC9, i, 1'b0), 1'b0);
    chk("left_word", data_out, 8'hC9);
    consume();

    // direction change after 3 right bits
    for (int i = 0; i < 3; i++) step(CTRL_RIGHT, 1'b1, 1'b0);
    for (int i = 0; i < FRAME_LEN; i++) begin
      step(CTRL_LEFT, frame_bit(1'b1, 8'h5A, i, 1'b0), 1'b0);
      if (i == 0) chk("dirchg_ferr", frame_error, 1);
    end
    chk("dirchg_word", data_out, 8'h5A);
    consume();

    // overrun
    send_frame(1'b0, 8'hAC, 1'b0, 1'b0, 1'b0);
    send_frame(1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
    chk("ovr_kept", data_out, 8'hAC);
    chk("ovr_flag", overrun, 1);
    consume();
    step(CTRL_CLEAR, 1'b0, 1'b0);

    // completion and consumption on the same edge
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    send_frame(1'b0, 8'hF0, 1'b0, 1'b1, 1'b0);
    chk("same_edge_word", data_out, 8'hF0);
    consume();

    // asynchronous reset mid-frame with a word held
    send_frame(1'b0, 8'hAC, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(CTRL_RIGHT, frame_bit(1'b0, 8'h33, i, 1'b0), 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_data_out", data_out, 0);
    chk("arst_valid", data_valid, 0);
    chk("arst_count", bit_count, 0);
    bits.delete(); sb.delete();
    m_valid = 0; m_over = 0; m_perr = 0; m_ferr = 0;
    @(posedge clock);
    #1 reset = 1'b0;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("post_rst_word", data_out, 8'h3C);
    consume();

`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
    send_frame(1'b0, 8'hAC, 1'b0, 1'b0, 1'b1);
    chk("parity_flag", parity_err, 1);
    consume();
    step(CTRL_CLEAR, 1'b0, 1'b0);
`endif

    // randomized traffic
    cur = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(99);
      if (r < 3) c = CTRL_CLEAR;
      else if (r < 13) c = CTRL_RETAIN;
      else begin
        if (r < 18) cur = ~cur;
        c = {1'b0, cur};
      end
      step(c, 1'($urandom_range(1)), 1'($urandom_range(99) < 60));
    end

    for (int n = 0; n < 4; n++) step(CTRL_RETAIN, 1'b0, 1'b1);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
